seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the count game's multiplexed 7-segment display driver. It samples the scanned `seg`/`dig` bus, which shows one digit at a time, and rebuilds the eight displayed characters as hex values. Each completed scan frame is committed to stable output registers. The block sits beside `game_top`, fed from its `seg`/`dig` outputs, and provides score readback and self-checking without an external display.

## Interface
- `STABLE_CYCLES`, 2: consecutive cycles a `{seg,dig}` pair must be held before capture (1..15).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `seg`  in  8  segment bus, active high; bit0=a … bit6=g, bit7=dp.
- `dig`  in  8  digit select, active-low one-hot; `dig[0]` = rightmost digit.
- `clear`  in  1  synchronous clear of frame state, error and counter.
- `digit_val`  out  32  committed hex value, nibble i = digit i.
- `digit_blank`  out  8  committed: digit i was blank (`seg[6:0]==0`).
- `digit_bad`  out  8  committed: digit i showed an undecodable pattern.
- `dp`  out  8  committed decimal-point state per digit.
- `frame_valid`  out  1  one-cycle pulse when a full frame is committed.
- `frame_cnt`  out  16  committed-frame counter; wraps at 16'hFFFF→0.
- `err`  out  1  sticky: a non-one-hot, non-idle `dig` was sampled.

## Operation
- Input stage: `seg`/`dig` are registered once (`s_seg`, `s_dig`). All decisions use the registered values.
- Stability counter: when `{s_seg,s_dig}` differs from the previous registered pair, the counter loads 1. Otherwise it increments, saturating at `STABLE_CYCLES`.
- Capture event: the counter becomes `STABLE_CYCLES` on this edge, including the load-to-1 case when `STABLE_CYCLES=1`. There is exactly one capture per hold.
- On a capture, `s_dig` is classified:
  - `dig==8'hFF` (idle): no capture, no error.
  - Exactly one bit low at index i: live registers for digit i are written and `seen[i]` is set.
  - Any other value: `err` is set and nothing is captured.
- Decode of `s_seg[6:0]`:
  - 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 → 0..F.
  - 00 → value 0, blank=1.
  - Any other pattern → value 0, bad=1.
  - `dp` = `s_seg[7]`.
- Frame commit: when `seen`, including this edge's capture, equals 8'hFF, all live registers are copied to the committed outputs, `seen` is cleared, `frame_cnt` increments and `frame_valid` pulses.
- The capture that completes a frame is included in the committed value on the same edge.
- Recapturing an already-seen digit before the frame completes overwrites its live value; `seen` is unchanged.
- `clear` has priority over capture and commit. It zeroes `seen`, `err`, `frame_cnt` and the live registers. Committed value outputs keep their state.
- Reset mid-frame discards the partial frame. The next commit requires all eight digits again.

## Timing
- Reset values: `digit_val`=0, `digit_blank`=0, `digit_bad`=0, `dp`=0, `frame_valid`=0, `frame_cnt`=0, `err`=0. All internal registers are 0, except the stored previous pair, which resets to `{8'h00,8'hFF}`.
- Latency: the pair is present before edge k and registered at k. Capture happens at edge k+`STABLE_CYCLES`−1 if the pair is held.
- A completing capture sets `frame_valid`=1 and updates the committed outputs in the cycle after the capture edge. `frame_valid` is high for exactly one cycle.
- A hold shorter than `STABLE_CYCLES` registered cycles is ignored.
- `err` rises in the cycle after the offending capture edge and stays high until `rst` or `clear`.
- Back-to-back frames are allowed with no dead cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `frame_valid` stays 0 after release.
- Full frame, `STABLE_CYCLES`=2: scan digits 0..7 showing 3F,06,5B,4F,66,6D,7D,07, each held 4 cycles → one `frame_valid` pulse, `digit_val`=32'h76543210, `digit_blank`=0, `frame_cnt`=1.
- Glitch rejection: insert a 1-cycle `dig`=8'b11101111 / `seg`=7F between digits → no capture; `digit_val` nibble 4 reflects only held values.
- Bad select: hold `dig`=8'b11111100 for 4 cycles → `err`=1, `seen` unchanged, no `frame_valid`. `clear` → `err`=0.
- Undecodable/blank/dp: digit 2 shows 49, digit 5 shows 00, digit 0 shows 86 → `digit_bad`=8'h04, `digit_blank`=8'h20, `dp`=8'h01, nibble 0 = 1.
- Reset mid-frame and wrap: pulse `rst` after 5 digits → no commit until 8 new digits. Separately, preload `frame_cnt` via 65535 frames or a forced value → next frame gives `frame_cnt`=0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose: watches the multiplexed 7-segment bus of the display driver and
// rebuilds the eight displayed characters as hex nibbles. Each digit must be
// held stable for STABLE_CYCLES registered cycles before it is captured into a
// live frame. Once all eight digits have been seen, the live frame is copied to
// the committed output registers and frame_valid pulses for one cycle.
//
// Parameters:
//   STABLE_CYCLES  consecutive cycles a {seg,dig} pair must be held (1..15)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   seg[7:0]     in   segment bus, active high (bit0=a .. bit6=g, bit7=dp)
//   dig[7:0]     in   digit select, active-low one-hot, dig[0]=rightmost
//   clear        in   synchronous clear of frame state, error and frame count
//   digit_val    out  committed hex value, nibble i = digit i
//   digit_blank  out  committed: digit i was blank
//   digit_bad    out  committed: digit i showed an undecodable pattern
//   dp           out  committed decimal-point state per digit
//   frame_valid  out  one-cycle pulse when a full frame is committed
//   frame_cnt    out  committed-frame counter, wraps 16'hFFFF -> 0
//   err          out  sticky: a non-one-hot, non-idle dig was captured
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [7:0]  dig,
   input  logic        clear,
   output logic [31:0] digit_val,
   output logic [7:0]  digit_blank,
   output logic [7:0]  digit_bad,
   output logic [7:0]  dp,
   output logic        frame_valid,
   output logic [15:0] frame_cnt,
   output logic        err
);

   localparam logic [3:0] STABLE_W = 4'(STABLE_CYCLES);

   // Decode a 7-segment pattern into {bad, blank, value[3:0]}.
   function automatic logic [5:0] decode_seg(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'h3F:   r = {2'b00, 4'h0};
         7'h06:   r = {2'b00, 4'h1};
         7'h5B:   r = {2'b00, 4'h2};
         7'h4F:   r = {2'b00, 4'h3};
         7'h66:   r = {2'b00, 4'h4};
         7'h6D:   r = {2'b00, 4'h5};
         7'h7D:   r = {2'b00, 4'h6};
         7'h07:   r = {2'b00, 4'h7};
         7'h7F:   r = {2'b00, 4'h8};
         7'h6F:   r = {2'b00, 4'h9};
         7'h77:   r = {2'b00, 4'hA};
         7'h7C:   r = {2'b00, 4'hB};
         7'h39:   r = {2'b00, 4'hC};
         7'h5E:   r = {2'b00, 4'hD};
         7'h79:   r = {2'b00, 4'hE};
         7'h71:   r = {2'b00, 4'hF};
         7'h00:   r = {2'b01, 4'h0};
         default: r = {2'b10, 4'h0};
      endcase
      return r;
   endfunction

   // True when exactly one bit of the active-low select is low.
   function automatic logic one_low(input logic [7:0] d);
      logic [7:0] inv;
      inv = ~d;
      return (inv != 8'h00) && ((inv & (inv - 8'd1)) == 8'h00);
   endfunction

   // Index of the (single) low bit of the select.
   function automatic logic [2:0] low_index(input logic [7:0] d);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!d[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Input stage and stability tracking
   logic [7:0]  s_seg_q, s_seg_d;
   logic [7:0]  s_dig_q, s_dig_d;
   logic [3:0]  stab_cnt_q, stab_cnt_d;

   // Live (partial) frame
   logic [31:0] live_val_q, live_val_d;
   logic [7:0]  live_blank_q, live_blank_d;
   logic [7:0]  live_bad_q, live_bad_d;
   logic [7:0]  live_dp_q, live_dp_d;
   logic [7:0]  seen_q, seen_d;

   // Committed outputs and status
   logic [31:0] digit_val_q, digit_val_d;
   logic [7:0]  digit_blank_q, digit_blank_d;
   logic [7:0]  digit_bad_q, digit_bad_d;
   logic [7:0]  dp_q, dp_d;
   logic        frame_valid_q, frame_valid_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        err_q, err_d;

   // Combinational helpers
   logic        pair_chg_s;
   logic        capture_s;
   logic [7:0]  cap_seg_s;
   logic [7:0]  cap_dig_s;
   logic [5:0]  dec_s;
   logic [2:0]  idx_s;
   logic [7:0]  seen_next_s;

   // Register the bus and track how long the current pair has been held.
   // The counter loads 1 on the edge that registers a new pair, so a capture
   // lands STABLE_CYCLES-1 edges after the pair is first registered.
   always_comb begin
      s_seg_d    = seg;
      s_dig_d    = dig;
      pair_chg_s = ({seg, dig} != {s_seg_q, s_dig_q});
      if (pair_chg_s) begin
         stab_cnt_d = 4'd1;
      end else if (stab_cnt_q < STABLE_W) begin
         stab_cnt_d = stab_cnt_q + 4'd1;
      end else begin
         stab_cnt_d = stab_cnt_q;
      end
      // Only the edge on which the count reaches the threshold captures; a
      // saturated counter stays put and produces no further captures.
      capture_s = (stab_cnt_d == STABLE_W) && (pair_chg_s || (stab_cnt_q != STABLE_W));
      // With a threshold above 1 the held pair is already in the input
      // register at capture time; with a threshold of 1 the capture happens on
      // the very edge that registers the pair, so the incoming value is used.
      if (STABLE_CYCLES == 1) begin
         cap_seg_s = seg;
         cap_dig_s = dig;
      end else begin
         cap_seg_s = s_seg_q;
         cap_dig_s = s_dig_q;
      end
      dec_s = decode_seg(cap_seg_s[6:0]);
      idx_s = low_index(cap_dig_s);
   end

   // Capture into the live frame, detect frame completion and commit.
   always_comb begin
      live_val_d    = live_val_q;
      live_blank_d  = live_blank_q;
      live_bad_d    = live_bad_q;
      live_dp_d     = live_dp_q;
      seen_d        = seen_q;
      seen_next_s   = seen_q;
      digit_val_d   = digit_val_q;
      digit_blank_d = digit_blank_q;
      digit_bad_d   = digit_bad_q;
      dp_d          = dp_q;
      frame_valid_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      err_d         = err_q;

      if (clear) begin
         live_val_d   = 32'h0000_0000;
         live_blank_d = 8'h00;
         live_bad_d   = 8'h00;
         live_dp_d    = 8'h00;
         seen_d       = 8'h00;
         err_d        = 1'b0;
         frame_cnt_d  = 16'h0000;
      end else begin
         if (capture_s && (cap_dig_s != 8'hFF)) begin
            if (one_low(cap_dig_s)) begin
               live_val_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
               live_blank_d[idx_s]             = dec_s[4];
               live_bad_d[idx_s]               = dec_s[5];
               live_dp_d[idx_s]                = cap_seg_s[7];
               seen_next_s                     = seen_q | (8'd1 << idx_s);
            end else begin
               err_d = 1'b1;
            end
         end else begin
            seen_next_s = seen_q;
         end

         // The completing capture is folded in by copying the updated live
         // values rather than the registered ones.
         if (seen_next_s == 8'hFF) begin
            digit_val_d   = live_val_d;
            digit_blank_d = live_blank_d;
            digit_bad_d   = live_bad_d;
            dp_d          = live_dp_d;
            seen_d        = 8'h00;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            frame_valid_d = 1'b1;
         end else begin
            seen_d = seen_next_s;
         end
      end
   end

   // State registers; the input register resets to the idle bus value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_seg_q       <= 8'h00;
         s_dig_q       <= 8'hFF;
         stab_cnt_q    <= 4'd0;
         live_val_q    <= 32'h0000_0000;
         live_blank_q  <= 8'h00;
         live_bad_q    <= 8'h00;
         live_dp_q     <= 8'h00;
         seen_q        <= 8'h00;
         digit_val_q   <= 32'h0000_0000;
         digit_blank_q <= 8'h00;
         digit_bad_q   <= 8'h00;
         dp_q          <= 8'h00;
         frame_valid_q <= 1'b0;
         frame_cnt_q   <= 16'h0000;
         err_q         <= 1'b0;
      end else begin
         s_seg_q       <= s_seg_d;
         s_dig_q       <= s_dig_d;
         stab_cnt_q    <= stab_cnt_d;
         live_val_q    <= live_val_d;
         live_blank_q  <= live_blank_d;
         live_bad_q    <= live_bad_d;
         live_dp_q     <= live_dp_d;
         seen_q        <= seen_d;
         digit_val_q   <= digit_val_d;
         digit_blank_q <= digit_blank_d;
         digit_bad_q   <= digit_bad_d;
         dp_q          <= dp_d;
         frame_valid_q <= frame_valid_d;
         frame_cnt_q   <= frame_cnt_d;
         err_q         <= err_d;
      end
   end

   assign digit_val   = digit_val_q;
   assign digit_blank = digit_blank_q;
   assign digit_bad   = digit_bad_q;
   assign dp          = dp_q;
   assign frame_valid = frame_valid_q;
   assign frame_cnt   = frame_cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Purpose: directed bench for seg_scan_decoder (STABLE_CYCLES = 2). Stimulus
// pushes the hand-computed committed frame into a queue; a monitor on the
// falling edge pops and compares whenever frame_valid is high. Status outputs
// (reset values, err, clear) are checked directly from the stimulus process.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg;
   logic [7:0]  dig;
   logic        clear;
   logic [31:0] digit_val;
   logic [7:0]  digit_blank;
   logic [7:0]  digit_bad;
   logic [7:0]  dp;
   logic        frame_valid;
   logic [15:0] frame_cnt;
   logic        err;

   seg_scan_decoder #(.STABLE_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .dig         (dig),
      .clear       (clear),
      .digit_val   (digit_val),
      .digit_blank (digit_blank),
      .digit_bad   (digit_bad),
      .dp          (dp),
      .frame_valid (frame_valid),
      .frame_cnt   (frame_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] val;
      logic [7:0]  blank;
      logic [7:0]  bad;
      logic [7:0]  dpv;
      logic [15:0] cnt;
   } frame_t;

   frame_t     exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       fv_prev = 1'b0;
   logic [7:0] pat [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // Monitor: compare each committed frame against the scoreboard.
   always @(negedge clk) begin
      frame_t e;
      if (frame_valid === 1'b1) begin
         check("fv_one_cycle", {31'd0, fv_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: actual val %h cnt %h required no frame", digit_val, frame_cnt);
         end else begin
            e = exp_q.pop_front();
            check("frame_val",   digit_val,           e.val);
            check("frame_blank", 32'(digit_blank),    32'(e.blank));
            check("frame_bad",   32'(digit_bad),      32'(e.bad));
            check("frame_dp",    32'(dp),             32'(e.dpv));
            check("frame_cnt",   32'(frame_cnt),      32'(e.cnt));
         end
      end
      fv_prev = frame_valid;
   end

   task automatic show(input logic [7:0] s, input logic [7:0] d, input int n);
      seg = s;
      dig = d;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_digit(input int i, input logic [7:0] p);
      show(p, ~(8'd1 << i), 4);
   endtask

   task automatic push(input logic [31:0] v, input logic [7:0] b, input logic [7:0] u,
                       input logic [7:0] d, input logic [15:0] c);
      frame_t f;
      f.val   = v;
      f.blank = b;
      f.bad   = u;
      f.dpv   = d;
      f.cnt   = c;
      exp_q.push_back(f);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_val"},   digit_val,          32'd0);
      check({tag, "_blank"}, 32'(digit_blank),   32'd0);
      check({tag, "_bad"},   32'(digit_bad),     32'd0);
      check({tag, "_dp"},    32'(dp),            32'd0);
      check({tag, "_fv"},    32'(frame_valid),   32'd0);
      check({tag, "_cnt"},   32'(frame_cnt),     32'd0);
      check({tag, "_err"},   32'(err),           32'd0);
   endtask

   initial begin
      logic [7:0] pv;
      pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      rst   = 1'b1;
      clear = 1'b0;
      seg   = 8'h00;
      dig   = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      show(8'h00, 8'hFF, 3);
      check("fv_after_reset", 32'(frame_valid), 32'd0);

      // Frame 1: digits 0..7 showing 0..7.
      push(32'h7654_3210, 8'h00, 8'h00, 8'h00, 16'd1);
      for (int i = 0; i < 8; i++) put_digit(i, pat[i]);
      show(8'h00, 8'hFF, 4);
      check("err_clean", 32'(err), 32'd0);

      // Frame 2: a one-cycle glitch showing 8 on digit 4 after its real value.
      push(32'h7654_3210, 8'h00, 8'h00, 8'h00, 16'd2);
      for (int i = 0; i < 5; i++) put_digit(i, pat[i]);
      show(8'h7F, 8'hEF, 1);
      for (int i = 5; i < 8; i++) put_digit(i, pat[i]);
      show(8'h00, 8'hFF, 4);

      // Frame 3: bad select held mid-frame; the partial frame must survive.
      push(32'h7654_3210, 8'h00, 8'h00, 8'h00, 16'd3);
      for (int i = 0; i < 3; i++) put_digit(i, pat[i]);
      show(8'h3F, 8'hFC, 4);
      check("err_bad_select", 32'(err), 32'd1);
      for (int i = 3; i < 8; i++) put_digit(i, pat[i]);
      show(8'h00, 8'hFF, 4);
      check("err_sticky", 32'(err), 32'd1);

      // Clear drops err and the counter but keeps committed values.
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clear_err", 32'(err), 32'd0);
      check("clear_cnt", 32'(frame_cnt), 32'd0);
      check("clear_keeps_val", digit_val, 32'h7654_3210);

      // Frame 4: undecodable digit 2, blank digit 5, dp on digit 0.
      push(32'h7604_3011, 8'h20, 8'h04, 8'h01, 16'd1);
      put_digit(0, 8'h86);
      put_digit(1, 8'h06);
      put_digit(2, 8'h49);
      put_digit(3, 8'h4F);
      put_digit(4, 8'h66);
      put_digit(5, 8'h00);
      put_digit(6, 8'h7D);
      put_digit(7, 8'h07);
      show(8'h00, 8'hFF, 4);

      // Partial frame of 8s on digits 3..7, then asynchronous reset mid-cycle.
      for (int i = 3; i < 8; i++) put_digit(i, 8'h7F);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      show(8'h00, 8'hFF, 3);
      check("fv_after_midreset", 32'(frame_valid), 32'd0);

      // Frame 5: a full fresh scan is needed; digits show A,B,C,D,E,F,8,9.
      push(32'h98FE_DCBA, 8'h00, 8'h00, 8'h00, 16'd1);
      for (int i = 0; i < 8; i++) begin
         pv = (i < 6) ? pat[i + 10] : pat[i + 2];
         put_digit(i, pv);
      end
      show(8'h00, 8'hFF, 4);

      // Frame 6: counter preset to its maximum wraps to zero.
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      @(posedge clk);
      #1;
      push(32'h7654_3210, 8'h00, 8'h00, 8'h00, 16'd0);
      for (int i = 0; i < 8; i++) put_digit(i, pat[i]);
      show(8'h00, 8'hFF, 6);

      check("frames_outstanding", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
